// File: rtl/pe_cube_result_drain_if.sv
// Result-drain bus: pe_cube snapshot capture on one side, beat stream and overflow status on the
// other. The master modport belongs to the drain; slave is its environment.
interface pe_cube_result_drain_if #(
    parameter int unsigned ArrayNum = 3,
    parameter int unsigned BlockNum = 3,
    parameter int unsigned CubeNum  = 3,
    parameter int unsigned OutBytes = 3
) ();
    localparam int unsigned Total = ArrayNum * BlockNum * CubeNum;

    logic                    result_valid;
    logic [8*Total-1:0]      result;
    logic                    clear_acc;
    logic                    valid;
    logic                    ready;
    logic [8*OutBytes-1:0]   data;
    logic                    last;
    logic                    overflow;
    logic [7:0]              drop_cnt;
    logic                    clear_overflow;

    modport master (
        input  result_valid,
        input  result,
        input  ready,
        input  clear_overflow,
        output clear_acc,
        output valid,
        output data,
        output last,
        output overflow,
        output drop_cnt
    );

    modport slave (
        output result_valid,
        output result,
        output ready,
        output clear_overflow,
        input  clear_acc,
        input  valid,
        input  data,
        input  last,
        input  overflow,
        input  drop_cnt
    );
endinterface

// File: rtl/pe_cube_result_drain.sv
// Captures pe_cube result snapshots into a two-slot ping-pong buffer and streams them out as
// fixed-width beats over valid/ready; all stream outputs come straight from registers.
module pe_cube_result_drain #(
    parameter int unsigned ArrayNum = 3,
    parameter int unsigned BlockNum = 3,
    parameter int unsigned CubeNum  = 3,
    parameter int unsigned OutBytes = 3
) (
    input logic                     clk_i,
    input logic                     rst_i,
    pe_cube_result_drain_if.master  bus
);
    localparam int unsigned Total    = ArrayNum * BlockNum * CubeNum;
    localparam int unsigned Beats    = (Total + OutBytes - 1) / OutBytes;
    localparam int unsigned PadBytes = Beats * OutBytes;
    localparam int unsigned BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [8*Total-1:0]      slot_q [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic                    valid_q;
    logic [8*OutBytes-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    clear_acc_q;
    logic                    overflow_q, overflow_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    logic                    fire, pop, accept, drop;
    logic [8*Total-1:0]      next_slot;
    logic [8*PadBytes-1:0]   padded;

    always_comb begin
        fire   = (state_q == StSend) && bus.ready;
        pop    = fire && (beat_q == LastBeat);
        // A slot freed by this edge's final-beat pop is available to a capture on the same edge.
        accept = bus.result_valid && ((count_q != 2'd2) || pop);
        drop   = bus.result_valid && !accept;

        count_d  = count_q - {1'b0, pop} + {1'b0, accept};
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ pop;

        beat_d = beat_q;
        if (fire) begin
            beat_d = pop ? '0 : beat_q + BeatW'(1);
        end

        state_d = (count_d != 2'd0) ? StSend : StIdle;

        // The slot presented next may be the one being written on this very edge.
        next_slot = (accept && (wr_ptr_q == rd_ptr_d)) ? bus.result : slot_q[rd_ptr_d];
        padded = '0;
        padded[8*Total-1:0] = next_slot;
        data_d = '0;
        last_d = 1'b0;
        if (state_d == StSend) begin
            data_d = padded[8*OutBytes*int'(beat_d) +: 8*OutBytes];
            last_d = (beat_d == LastBeat);
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hff) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            slot_q      <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            beat_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            clear_acc_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            if (accept) begin
                slot_q[wr_ptr_q] <= bus.result;
            end
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            valid_q     <= (state_d == StSend);
            data_q      <= data_d;
            last_q      <= last_d;
            // Pulses for every strobe, accepted or dropped, so pe_cube never sees backpressure.
            clear_acc_q <= bus.result_valid;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.valid     = valid_q;
    assign bus.data      = data_q;
    assign bus.last      = last_q;
    assign bus.clear_acc = clear_acc_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule
